// File: rtl/controller_part4_pkg.sv
// Shared types and constants for the part4 matrix-vector controller.
package part4_pkg;
  localparam int unsigned N       = 8;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned ACC_W   = 28;
  localparam int unsigned LAT     = 3;
  localparam int unsigned ROW_W   = 3;
  localparam int unsigned WADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_X  = 2'd1,
    LOAD_W  = 2'd2,
    COMPUTE = 2'd3
  } state_e;
endpackage

// File: rtl/controller_part4_if.sv
// Control bus between the part4 controller (master) and its datapath/environment (slave).
interface controller_part4_if;
  import part4_pkg::*;

  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [ROW_W-1:0]   addr_x;
  logic               wr_en_x;
  logic [WADDR_W-1:0] addr_w;
  logic               wr_en_w;
  logic               clear_acc;
  logic               en_acc;
  logic               en_pipe;
  logic               out_valid;
  logic               out_ready;
  logic [ROW_W-1:0]   out_row;
  logic               busy;
  logic               done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, addr_x, wr_en_x, addr_w, wr_en_w,
           clear_acc, en_acc, en_pipe, out_valid, out_row, busy, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, addr_x, wr_en_x, addr_w, wr_en_w,
           clear_acc, en_acc, en_pipe, out_valid, out_row, busy, done
  );
endinterface

// File: rtl/controller_part4.sv
// Sequences x/W loading and an 8-row, 3-stage multiply/add/accumulate pass with
// output backpressure; the datapath itself lives outside this block.
module controller_part4 #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 14
) (
  input logic                 clk,
  input logic                 rst,
  controller_part4_if.master  bus
);
  import part4_pkg::*;

  if (N != 8 || 2 * DATA_W > ACC_W) begin : g_bad_params
    $error("controller_part4: only N=8 with 2*DATA_W <= ACC_W is supported");
  end

  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(N - 1);
  localparam logic [WADDR_W-1:0] LAST_W   = WADDR_W'(N * N - 1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   x_cnt_q, x_cnt_d;
  logic [WADDR_W-1:0] w_cnt_q, w_cnt_d;
  logic [ROW_W-1:0]   issue_row_q, issue_row_d;
  logic               issue_done_q, issue_done_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               s1_q, s1_d, s2_q, s2_d;
  logic               out_valid_q, out_valid_d;
  logic               adv, issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_cnt_q      <= '0;
      w_cnt_q      <= '0;
      issue_row_q  <= '0;
      issue_done_q <= 1'b0;
      out_row_q    <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      w_cnt_q      <= w_cnt_d;
      issue_row_q  <= issue_row_d;
      issue_done_q <= issue_done_d;
      out_row_q    <= out_row_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_cnt_d      = x_cnt_q;
    w_cnt_d      = w_cnt_q;
    issue_row_d  = issue_row_q;
    issue_done_d = issue_done_q;
    out_row_d    = out_row_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    out_valid_d  = out_valid_q;
    adv          = 1'b0;
    issue        = 1'b0;

    bus.in_ready  = 1'b0;
    bus.addr_x    = '0;
    bus.wr_en_x   = 1'b0;
    bus.addr_w    = '0;
    bus.wr_en_w   = 1'b0;
    bus.clear_acc = 1'b0;
    bus.en_acc    = 1'b0;
    bus.en_pipe   = 1'b0;
    bus.done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.clear_acc = 1'b1;
        x_cnt_d       = '0;
        w_cnt_d       = '0;
        issue_row_d   = '0;
        issue_done_d  = 1'b0;
        out_row_d     = '0;
        s1_d          = 1'b0;
        s2_d          = 1'b0;
        out_valid_d   = 1'b0;
        if (bus.start) state_d = LOAD_X;
      end
      LOAD_X: begin
        bus.in_ready = 1'b1;
        bus.addr_x   = x_cnt_q;
        if (bus.in_valid) begin
          bus.wr_en_x = 1'b1;
          x_cnt_d     = x_cnt_q + 1'b1;
          if (x_cnt_q == LAST_ROW) state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        bus.in_ready = 1'b1;
        bus.addr_w   = w_cnt_q;
        if (bus.in_valid) begin
          bus.wr_en_w = 1'b1;
          w_cnt_d     = w_cnt_q + 1'b1;
          if (w_cnt_q == LAST_W) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // Every pipeline register, including the datapath's, moves only on adv.
        adv         = !out_valid_q || bus.out_ready;
        bus.en_pipe = adv;
        bus.addr_w  = {issue_row_q, 3'b000};
        if (adv) begin
          issue      = !issue_done_q;
          s1_d       = issue;
          s2_d       = s1_q;
          bus.en_acc = s2_q;
          if (issue) begin
            issue_row_d = issue_row_q + 1'b1;
            if (issue_row_q == LAST_ROW) issue_done_d = 1'b1;
          end
        end
        if (bus.en_acc) out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
        if (out_valid_q && bus.out_ready) begin
          out_row_d = out_row_q + 1'b1;
          if (out_row_q == LAST_ROW) begin
            bus.done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
